mem_stage_ctrl: RTL
===================

// Module: mem_stage_ctrl
// PURPOSE
//  Memory-stage consumer of the 76-bit EX/MEM buffer. It decodes the bundle, runs the 16-bit
//  data-memory req/ack handshake, and splits 32-bit PC push/pop into two word accesses.
//  It restores flags and PC on pops, stalls upstream while busy, and registers the MEM/WB outputs.
// PARAMETERS
//  ADDR_W       12   data-memory word-address width; uses Address[ADDR_W-1:0]
//  TIMEOUT      15   max cycles waiting for mem_ack per access before abort
// PORTS
//  clk            in   1   rising-edge clock
//  rst_n          in   1   asynchronous active-low reset
//  ex_valid       in   1   EX/MEM bundle valid this cycle
//  EXMEMBuffer    in   76  [31:0]Data [34:32]WB_Address [35]MR [36]MW [37]WB [69:38]Address
//                          [70]JWSP [71]Stack_PC [72]Stack_Flags [75:73]Final_Flags(NF|CF|ZF)
//  stall          out  1   hold EX/MEM and earlier stages; bundle must stay stable while high
//  mem_req        out  1   access request, held until mem_ack
//  mem_we         out  1   1=write, 0=read; valid with mem_req
//  mem_addr       out  ADDR_W  word address
//  mem_wdata      out  16  write data
//  mem_rdata      in   16  read data, valid with mem_ack
//  mem_ack        in   1   one-cycle completion pulse
//  wb_valid       out  1   MEM/WB output valid (1-cycle pulse per retired bundle)
//  wb_en          out  1   register write enable (bundle WB)
//  wb_addr        out  3   destination register
//  wb_data        out  16  MR ? mem_rdata : Data[15:0]
//  pc_load        out  1   1-cycle pulse: pc_value valid (PC pop with JWSP)
//  pc_value       out  32  popped PC {hi,lo}
//  flags_load     out  1   1-cycle pulse: flags_value valid
//  flags_value    out  3   MR&Stack_Flags ? mem_rdata[2:0] : Final_Flags
//  err            out  1   sticky; set on timeout or MR&MW; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0. FSM=IDLE. Counters and capture registers are 0.
//  Reset mid-access drops mem_req asynchronously and discards the in-flight bundle without retiring it.
//  FSM: IDLE, ACC_HI, ACC_LO, RETIRE.
//  IDLE, ex_valid & ~MR & ~MW: register the outputs. wb_valid is asserted the next cycle (latency 1).
//    stall stays 0. flags_load=1 carries Final_Flags.
//  IDLE, ex_valid & (MR^MW): capture the bundle and go to ACC_HI. stall=1 combinationally this cycle.
//    stall stays 1 until the RETIRE cycle, where it drops.
//  ACC_HI: mem_req=1, addr=Address. Write data = Stack_PC ? Data[31:16] : Stack_Flags ? {13'b0,Final_Flags} : Data[15:0].
//    On ack: capture rdata into hi. If Stack_PC, go to ACC_LO; else go to RETIRE.
//  ACC_LO: addr=Address+1 (mod 2^ADDR_W, wraps), wdata=Data[15:0]. On ack, capture lo and go to RETIRE.
//  mem_req deasserts in the cycle after ack. There is no back-to-back req across states;
//    one idle cycle separates ACC_HI and ACC_LO.
//  RETIRE: wb_valid=1 for one cycle. pc_load=MR&Stack_PC&JWSP. flags_load=1 only for MR&Stack_Flags.
//    Next state is IDLE; a new bundle is accepted the following cycle.
//  Access latency: single-word = ack_wait+2 cycles. PC push/pop = 2*ack_wait+4 cycles.
//  Timeout: a 4-bit counter increments each cycle with mem_req & ~mem_ack.
//    When it reaches TIMEOUT: drop req, set err, go to RETIRE with wb_en=0 and pc_load=flags_load=0.
//  MR&MW together: illegal. Set err and retire as a NOP (wb_en=0), no memory access, latency 1.
//  mem_ack outside ACC_* is ignored. ex_valid while stall=1 is the same held bundle and is not re-issued.
//  Stack_PC and Stack_Flags both set: Stack_PC has priority; Stack_Flags is ignored.
// TESTING
//  ALU bundle Data=16'd137, WB=1, WB_Address=3 -> next cycle wb_valid=1, wb_addr=3, wb_data=137; stall never high.
//  MR, Address=0x010, ack after 3 cycles, rdata=0xBEEF -> stall 5 cycles, wb_data=0xBEEF, mem_we=0.
//  PC push (MW, Stack_PC, Data=0x0001_0023, Address=0xFFF) -> writes 0x0001@0xFFF, 0x0023@0x000 (wrap).
//  PC pop (MR, Stack_PC, JWSP, rdata 0x0001 then 0x0023) -> pc_load pulse, pc_value=0x00010023.
//  No ack for TIMEOUT cycles -> mem_req drops, err=1, wb_valid with wb_en=0; rst_n low mid-access clears all.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//   Memory-stage consumer of the 76-bit EX/MEM bundle. It decodes the bundle and
//   runs a 16-bit data-memory req/ack handshake. A 32-bit PC push/pop is split into
//   two word accesses (hi at Address, lo at Address+1). On pops it restores flags
//   and the PC. It stalls upstream while busy and registers the MEM/WB outputs.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   ex_valid, EXMEMBuffer  EX/MEM bundle and its valid flag
//   stall                 holds EX/MEM and earlier stages while an access is in flight
//   mem_req/we/addr/wdata  data-memory request side, held until mem_ack
//   mem_rdata, mem_ack     data-memory response (one-cycle ack pulse)
//   wb_valid/en/addr/data  MEM/WB register-write outputs (wb_valid pulses once per bundle)
//   pc_load, pc_value      popped PC, valid for one cycle
//   flags_load/value       flags to restore, valid for one cycle
//   err                   sticky error: access timeout or MR&MW bundle
module mem_stage_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [75:0]       EXMEMBuffer,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [2:0]        wb_addr,
    output logic [15:0]       wb_data,
    output logic              pc_load,
    output logic [31:0]       pc_value,
    output logic              flags_load,
    output logic [2:0]        flags_value,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, ACC_HI, ACC_LO, RETIRE} state_t;

    state_t state, state_nxt;

    // Bundle decode
    logic [31:0]       in_data;
    logic [2:0]        in_wba, in_ff;
    logic              in_mr, in_mw, in_wb, in_jwsp, in_spc, in_sflg;
    logic [ADDR_W-1:0] in_addr;

    assign in_data = EXMEMBuffer[31:0];
    assign in_wba  = EXMEMBuffer[34:32];
    assign in_mr   = EXMEMBuffer[35];
    assign in_mw   = EXMEMBuffer[36];
    assign in_wb   = EXMEMBuffer[37];
    assign in_addr = EXMEMBuffer[38 +: ADDR_W];
    assign in_jwsp = EXMEMBuffer[70];
    assign in_spc  = EXMEMBuffer[71];
    assign in_sflg = EXMEMBuffer[72];
    assign in_ff   = EXMEMBuffer[75:73];

    generate
        if (ADDR_W < 32) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^EXMEMBuffer[69:38+ADDR_W];
        end
    endgenerate

    // Captured bundle for the duration of an access
    logic [31:0]       cap_data;
    logic [2:0]        cap_wba, cap_ff;
    logic              cap_mr, cap_mw, cap_wb, cap_jwsp, cap_spc, cap_sflg;
    logic [ADDR_W-1:0] cap_addr;
    logic [15:0]       hi_q;
    logic [3:0]        cnt;
    logic              gap;     // first ACC_LO cycle: request held low for one cycle
    logic              ack_ok, to_hit;

    assign ack_ok = mem_req & mem_ack;
    assign to_hit = mem_req & ~mem_ack & (cnt == 4'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ex_valid && (in_mr ^ in_mw)) state_nxt = ACC_HI;
            ACC_HI:  if (ack_ok)      state_nxt = cap_spc ? ACC_LO : RETIRE;
                     else if (to_hit) state_nxt = RETIRE;
            ACC_LO:  if (ack_ok || to_hit) state_nxt = RETIRE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory-side and stall outputs
    always_comb begin
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: stall = ex_valid & (in_mr ^ in_mw);
            ACC_HI: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = cap_mw;
                mem_addr  = cap_addr;
                mem_wdata = cap_spc  ? cap_data[31:16] :
                            cap_sflg ? {13'b0, cap_ff} : cap_data[15:0];
            end
            ACC_LO: begin
                stall = 1'b1;
                if (!gap) begin
                    mem_req   = 1'b1;
                    mem_we    = cap_mw;
                    mem_addr  = cap_addr + ADDR_W'(1);
                    mem_wdata = cap_data[15:0];
                end
            end
            default: ;
        endcase
    end

    // Per-access timeout counter; restarts whenever the request is idle or acked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 cnt <= '0;
        else if (!mem_req || mem_ack) cnt <= '0;
        else                        cnt <= cnt + 4'd1;
    end

    // Capture, MEM/WB output registers and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_data    <= '0;
            cap_wba     <= '0;
            cap_ff      <= '0;
            cap_mr      <= 1'b0;
            cap_mw      <= 1'b0;
            cap_wb      <= 1'b0;
            cap_jwsp    <= 1'b0;
            cap_spc     <= 1'b0;
            cap_sflg    <= 1'b0;
            cap_addr    <= '0;
            hi_q        <= '0;
            gap         <= 1'b0;
            wb_valid    <= 1'b0;
            wb_en       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            pc_load     <= 1'b0;
            pc_value    <= '0;
            flags_load  <= 1'b0;
            flags_value <= '0;
            err         <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            wb_en      <= 1'b0;
            pc_load    <= 1'b0;
            flags_load <= 1'b0;
            gap        <= (state == ACC_HI) && ack_ok && cap_spc;

            if (state == IDLE && ex_valid) begin
                if (in_mr && in_mw) begin
                    // Illegal bundle retires as a NOP with no memory access
                    err      <= 1'b1;
                    wb_valid <= 1'b1;
                end else if (!in_mr && !in_mw) begin
                    wb_valid    <= 1'b1;
                    wb_en       <= in_wb;
                    wb_addr     <= in_wba;
                    wb_data     <= in_data[15:0];
                    flags_load  <= 1'b1;
                    flags_value <= in_ff;
                end else begin
                    cap_data <= in_data;
                    cap_wba  <= in_wba;
                    cap_ff   <= in_ff;
                    cap_mr   <= in_mr;
                    cap_mw   <= in_mw;
                    cap_wb   <= in_wb;
                    cap_jwsp <= in_jwsp;
                    cap_spc  <= in_spc;
                    cap_sflg <= in_sflg & ~in_spc;   // PC stacking wins over flags
                    cap_addr <= in_addr;
                end
            end

            if (state == ACC_HI && ack_ok)
                hi_q <= mem_rdata;

            // Final ack of the bundle: load the MEM/WB registers for the RETIRE cycle
            if ((state == ACC_HI && ack_ok && !cap_spc) || (state == ACC_LO && ack_ok)) begin
                wb_valid    <= 1'b1;
                wb_en       <= cap_wb;
                wb_addr     <= cap_wba;
                wb_data     <= cap_mr ? mem_rdata : cap_data[15:0];
                flags_load  <= cap_mr & cap_sflg;
                flags_value <= (cap_mr && cap_sflg) ? mem_rdata[2:0] : cap_ff;
                if (state == ACC_LO) begin
                    pc_value <= {hi_q, mem_rdata};
                    pc_load  <= cap_mr & cap_jwsp;
                end
            end

            if (to_hit) begin
                err      <= 1'b1;
                wb_valid <= 1'b1;
                wb_addr  <= cap_wba;
            end
        end
    end

endmodule
